// File: rtl/mm2s_pkg.sv
// Shared definitions for the mm2s read path: FSM encoding, beat sideband and pixel packing helpers.
package mm2s_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH    = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_STREAM   = 2'd2
  } state_t;

  typedef struct packed {
    logic tuser;
    logic tlast;
    logic flast;
  } beat_meta_t;

  function automatic int pix_bytes(input int pixel_width);
    if (pixel_width <= 8) return 1;
    else if (pixel_width <= 16) return 2;
    else return 4;
  endfunction

  function automatic int pix_per_beat(input int data_width, input int pixel_width);
    return data_width / 8 / pix_bytes(pixel_width);
  endfunction

endpackage

// File: rtl/fifo2axis_video_if.sv
// AXI4-Stream video link: tuser = start of frame, tlast = end of line.
interface fifo2axis_video_if #(parameter int DW = 32);
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;
  logic          tready;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer with registered valid; enqueue-to-valid 1 cycle, 1 beat/cycle.
// Writer must never push when full; head entry holds steady while stalled. i_clr empties it.
module axis_skid_buf #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  input  logic         i_rdy,
  output logic [1:0]   o_cnt
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign w_pop = (r_cnt != 2'd0) & i_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_clr) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_vld) begin
        r_mem[r_wptr] <= i_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, i_vld} - {1'b0, w_pop};
    end
  end

  assign o_vld = (r_cnt != 2'd0);
  assign o_dat = r_mem[r_rptr];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo2axis_video.sv
// Frame FIFO to AXIS video master; regenerates SOF/EOL framing. FIFO-empty to TVALID 2 cycles,
// 1 beat/cycle; TREADY low stalls FIFO reads once the 2-entry buffer is committed.
module fifo2axis_video
  import mm2s_pkg::*;
#(
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12,
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_DATA_WIDTH  = 32
) (
  input  logic                    M_AXIS_ACLK,
  input  logic                    M_AXIS_ARESETN,
  input  logic                    soft_resetn,
  output logic                    resetting,
  input  logic [C_IMG_WBITS-1:0]  img_width,
  input  logic [C_IMG_HBITS-1:0]  img_height,
  output logic                    rd_en,
  input  logic [C_DATA_WIDTH-1:0] din,
  input  logic                    din_sof,
  input  logic                    din_eol,
  input  logic                    empty,
  fifo2axis_video_if.master       m_axis,
  output logic                    frame_done,
  output logic                    err_sync
);
  localparam int                     P      = pix_per_beat(C_DATA_WIDTH, C_PIXEL_WIDTH);
  localparam logic [C_IMG_WBITS-1:0] C_P    = C_IMG_WBITS'(P);
  localparam logic [C_IMG_HBITS-1:0] C_ONEH = C_IMG_HBITS'(1);
  localparam int                     BW     = C_DATA_WIDTH + $bits(beat_meta_t);

  state_t                  r_state, w_state_nxt;
  logic                    r_inflight;
  logic [C_IMG_WBITS-1:0]  r_col, w_col_nxt;
  logic [C_IMG_HBITS-1:0]  r_row, w_row_nxt;
  logic [C_IMG_WBITS-1:0]  r_width, w_width_nxt;
  logic                    r_err, w_err_nxt;
  logic                    w_enq;
  beat_meta_t              w_meta, w_out_meta;
  logic [C_DATA_WIDTH-1:0] w_out_data;
  logic [BW-1:0]           w_out_dat;
  logic                    w_out_vld;
  logic [1:0]              w_buf_cnt;
  logic                    w_hs;
  logic [2:0]              w_occ;

  assign w_hs  = w_out_vld & m_axis.tready;
  // Occupancy after this cycle's handshake, so a draining buffer can be refilled every cycle.
  assign w_occ = {1'b0, w_buf_cnt} + {2'b0, r_inflight} - {2'b0, w_hs};
  assign rd_en = ~empty & ((r_state == ST_FLUSH) | (w_occ < 3'd2));

  // r_col: pixels still to come in the current line after the last enqueued word.
  always_comb begin
    w_state_nxt = r_state;
    w_enq       = 1'b0;
    w_meta      = '0;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_width_nxt = r_width;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        if (soft_resetn & empty & ~r_inflight) w_state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF, ST_STREAM: begin
        if (r_inflight) begin
          if (din_sof) begin
            w_width_nxt  = img_width;
            w_col_nxt    = img_width - C_P;
            w_row_nxt    = img_height - C_ONEH;
            w_meta.tuser = 1'b1;
            w_enq        = 1'b1;
            w_err_nxt    = (r_state == ST_STREAM);
          end else if (r_state == ST_STREAM) begin
            if (r_col == '0) begin
              w_col_nxt = r_width - C_P;
              w_row_nxt = r_row - C_ONEH;
            end else begin
              w_col_nxt = r_col - C_P;
            end
            w_enq = 1'b1;
          end
          if (w_enq) begin
            w_meta.tlast = (w_col_nxt == '0);
            w_meta.flast = w_meta.tlast & (w_row_nxt == '0);
            w_err_nxt    = w_err_nxt | (din_eol != w_meta.tlast);
            w_state_nxt  = w_meta.flast ? ST_WAIT_SOF : ST_STREAM;
          end
        end
      end
      default: w_state_nxt = ST_FLUSH;
    endcase
    if (!soft_resetn) begin
      w_state_nxt = ST_FLUSH;
      w_enq       = 1'b0;
      w_err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_state    <= ST_FLUSH;
      r_inflight <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_width    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= rd_en;
      r_err      <= w_err_nxt;
      if (w_enq) begin
        r_col   <= w_col_nxt;
        r_row   <= w_row_nxt;
        r_width <= w_width_nxt;
      end
    end
  end

  axis_skid_buf #(.W(BW)) u_skid (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .i_clr ((r_state == ST_FLUSH) | ~soft_resetn),
    .i_vld (w_enq),
    .i_dat ({din, w_meta}),
    .o_vld (w_out_vld),
    .o_dat (w_out_dat),
    .i_rdy (m_axis.tready),
    .o_cnt (w_buf_cnt)
  );

  assign {w_out_data, w_out_meta} = w_out_dat;

  assign m_axis.tvalid = w_out_vld;
  assign m_axis.tdata  = w_out_data;
  assign m_axis.tuser  = w_out_meta.tuser;
  assign m_axis.tlast  = w_out_meta.tlast;
  assign frame_done    = w_hs & w_out_meta.flast;
  assign err_sync      = r_err;
  assign resetting     = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_fifo2axis_video.sv
// Scoreboard bench for fifo2axis_video: behavioural FIFO, frame-index reference model, AXIS monitor.
module tb_fifo2axis_video;
  localparam int WB = 12, HB = 12, DW = 32, P = 4;

  typedef struct packed { logic sof; logic eol; logic [DW-1:0] data; } word_t;
  typedef struct packed { logic [DW-1:0] data; logic tuser; logic tlast; logic flast; } exp_t;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          soft_resetn = 1'b0;
  logic          resetting, rd_en, frame_done, err_sync;
  logic [WB-1:0] img_width = 12'd8;
  logic [HB-1:0] img_height = 12'd2;
  logic [DW-1:0] din = '0;
  logic          din_sof = 1'b0, din_eol = 1'b0, empty = 1'b1;

  fifo2axis_video_if #(.DW(DW)) axis ();

  fifo2axis_video #(.C_IMG_WBITS(WB), .C_IMG_HBITS(HB), .C_PIXEL_WIDTH(8), .C_DATA_WIDTH(DW)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(arst_n), .soft_resetn(soft_resetn), .resetting(resetting),
    .img_width(img_width), .img_height(img_height), .rd_en(rd_en), .din(din), .din_sof(din_sof),
    .din_eol(din_eol), .empty(empty), .m_axis(axis), .frame_done(frame_done), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  int     total = 0, bad = 0, cyc = 0;
  word_t  fq[$];
  exp_t   exp_q[$];
  int     hs_cyc[$];
  int     first_tv = -1, t_ef = 0, rdy_mode = 0;
  bit     m_in = 0;
  int     m_k = 0, m_B = 1, m_N = 1, m_err = 0, m_fd = 0, obs_err = 0, obs_fd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want completion (cycle %0d)", nm, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: beat k of a frame with B beats/line and N beats/frame.
  task automatic push_word(input bit sof, input bit eol, input logic [DW-1:0] d);
    bit was_in;
    bit tl, fl;
    exp_t e;
    fq.push_back({sof, eol, d});
    was_in = m_in;
    if (sof) begin
      m_in = 1;
      m_k  = 0;
      m_B  = int'(img_width) / P;
      m_N  = m_B * int'(img_height);
    end
    if (m_in) begin
      tl = ((m_k % m_B) == m_B - 1);
      fl = (m_k == m_N - 1);
      if ((sof && was_in) || (eol != tl)) m_err++;
      e.data = d; e.tuser = (m_k == 0); e.tlast = tl; e.flast = fl;
      exp_q.push_back(e);
      m_k++;
      if (fl) begin
        m_in = 0;
        m_fd++;
      end
    end
  endtask

  task automatic send_frame(input int w, input int h, input int bad_eol_at);
    int b;
    img_width  = WB'(w);
    img_height = HB'(h);
    b = w / P;
    for (int k = 0; k < b * h; k++)
      push_word(k == 0, ((k % b) == b - 1) ^ (k == bad_eol_at), $urandom);
  endtask

  task automatic start_test();
    m_err = 0; m_fd = 0; obs_err = 0; obs_fd = 0;
    hs_cyc.delete();
    first_tv = -1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || axis.tvalid) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) timeout_fail(nm);
    repeat (4) step();
  endtask

  task automatic end_test(input string nm);
    check({nm, "_err_sync_count"}, 64'(obs_err), 64'(m_err));
    check({nm, "_frame_done_count"}, 64'(obs_fd), 64'(m_fd));
  endtask

  // Behavioural standard FIFO: data appears the cycle after a read strobe.
  initial begin
    bit    take;
    word_t w;
    forever begin
      @(negedge clk);
      take = rd_en && !empty;
      @(posedge clk);
      #1;
      if (take) begin
        w       = fq.pop_front();
        din     = w.data;
        din_sof = w.sof;
        din_eol = w.eol;
      end else begin
        din     = $urandom;
        din_sof = 1'($urandom_range(0, 1));
        din_eol = 1'($urandom_range(0, 1));
      end
      if (empty && fq.size() != 0) t_ef = cyc;
      empty = (fq.size() == 0);
    end
  end

  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ~axis.tready;
        2:       axis.tready = 1'($urandom_range(0, 1));
        default: axis.tready = 1'b0;
      endcase
    end
  end

  initial begin
    bit            prev_stall = 0;
    logic [DW+1:0] prev_beat = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (err_sync) obs_err++;
      if (frame_done) obs_fd++;
      if (arst_n) begin
        if (prev_stall && soft_resetn && !resetting) begin
          check("stall_tvalid", 64'(axis.tvalid), 64'(1));
          check("stall_beat", 64'({axis.tdata, axis.tuser, axis.tlast}), 64'(prev_beat));
        end
        if (axis.tvalid && axis.tready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got data %0h want no beat", axis.tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(axis.tdata), 64'(e.data));
            check("beat_tuser", 64'(axis.tuser), 64'(e.tuser));
            check("beat_tlast", 64'(axis.tlast), 64'(e.tlast));
            check("beat_frame_done", 64'(frame_done), 64'(e.flast));
          end
        end
        if (axis.tvalid && first_tv < 0) first_tv = cyc;
        prev_stall = axis.tvalid && !axis.tready;
        prev_beat  = {axis.tdata, axis.tuser, axis.tlast};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) step();
    check("rst_resetting", 64'(resetting), 64'(1));
    check("rst_tvalid", 64'(axis.tvalid), 64'(0));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_err_sync", 64'(err_sync), 64'(0));
    arst_n = 1'b1;
    step();
    soft_resetn = 1'b1;
    n = 0;
    while (resetting && n < 20) begin step(); n++; end
    if (n >= 20) timeout_fail("leave_flush");

    // 1: 8x2 preloaded, full rate
    start_test();
    rdy_mode = 0;
    send_frame(8, 2, -1);
    wait_idle("t1_idle");
    check("t1_empty_to_tvalid", 64'(first_tv - t_ef), 64'(2));
    check("t1_beats", 64'(hs_cyc.size()), 64'(4));
    if (hs_cyc.size() == 4) check("t1_back_to_back", 64'(hs_cyc[3] - hs_cyc[0]), 64'(3));
    end_test("t1");

    // 2: toggling ready; dimensions changed mid-frame must not matter
    start_test();
    rdy_mode = 1;
    send_frame(8, 2, -1);
    n = 0;
    while (hs_cyc.size() == 0 && n < 50) begin step(); n++; end
    if (n >= 50) timeout_fail("t2_first_beat");
    img_width  = 12'd4;
    img_height = 12'd1;
    wait_idle("t2_idle");
    end_test("t2");

    // 3: garbage before sof
    start_test();
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) push_word(1'b0, 1'($urandom_range(0, 1)), $urandom);
    send_frame(8, 2, -1);
    wait_idle("t3_idle");
    end_test("t3");

    // 4: missing eol on beat 1
    start_test();
    send_frame(8, 2, 1);
    wait_idle("t4_idle");
    end_test("t4");

    // 5: sof arrives at beat 2 of a 16x2 frame
    start_test();
    img_width  = 12'd16;
    img_height = 12'd2;
    push_word(1'b1, 1'b0, $urandom);
    push_word(1'b0, 1'b0, $urandom);
    send_frame(16, 2, -1);
    wait_idle("t5_idle");
    end_test("t5");

    // 6: soft reset mid-frame while stalled
    start_test();
    rdy_mode = 3;
    send_frame(8, 4, -1);
    repeat (8) step();
    soft_resetn = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].flast) m_fd--;
    exp_q.delete();
    m_in = 0;
    step();
    check("t6_resetting", 64'(resetting), 64'(1));
    check("t6_tvalid", 64'(axis.tvalid), 64'(0));
    n = 0;
    while ((fq.size() != 0 || !empty) && n < 50) begin step(); n++; end
    if (n >= 50) timeout_fail("t6_drain");
    repeat (3) step();
    check("t6_still_resetting", 64'(resetting), 64'(1));
    soft_resetn = 1'b1;
    n = 0;
    while (resetting && n < 20) begin step(); n++; end
    if (n >= 20) timeout_fail("t6_release");
    check("t6_released", 64'(resetting), 64'(0));
    rdy_mode = 0;
    send_frame(8, 2, -1);
    wait_idle("t6_idle");
    end_test("t6");

    // 7: randomized frames, including a single-beat 4x1 frame
    start_test();
    rdy_mode = 2;
    send_frame(4, 1, -1);
    wait_idle("t7_single");
    for (int f = 0; f < 10; f++) begin
      int w, h, nb, g;
      w  = 4 * $urandom_range(1, 4);
      h  = $urandom_range(1, 3);
      nb = (w / P) * h;
      g  = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) push_word(1'b0, 1'b0, $urandom);
      send_frame(w, h, ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1);
      wait_idle("t7_idle");
    end
    end_test("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
